cpuif_rr_arbiter: RTL and testbench

//  Shares one regblock generic CPU interface (cpuif_*) between N_REQ independent requesters.

---
 rtl/cpuif_rr_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_cpuif_rr_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpuif_rr_arbiter.sv
// cpuif_rr_arbiter: shares one regblock generic CPU interface between N_REQ
// requesters. Round-robin grant, one transaction outstanding, response routed
// to the issuing requester only. All outputs are registered.
//
// Ports:
//   clk, arst_n                       clock, async active-low reset
//   req_vld/req_is_wr                 per-requester valid / write flag
//   req_addr/req_wr_data/req_wr_biten packed payloads, requester i at [i*W +: W]
//   req_accept                        1-cycle pulse, request latched
//   rsp_ack/rsp_err/rsp_rd_data       1-cycle completion to grantee
//   cpuif_*                           regblock generic CPU interface
//   grant_id                          current/last grantee
//   busy                              FSM not idle
//   timeout_evt                       1-cycle pulse on forced completion
//
// Build option: define CPUIF_ARB_TIMEOUT_EN to force an error completion after
// TIMEOUT_CYCLES cycles in ISSUE+WAIT. Undefined: waits indefinitely.
module cpuif_rr_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic [N_REQ-1:0]           req_vld,
  input  logic [N_REQ-1:0]           req_is_wr,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_wr_data,
  input  logic [N_REQ*DATA_W-1:0]    req_wr_biten,
  output logic [N_REQ-1:0]           req_accept,
  output logic [N_REQ-1:0]           rsp_ack,
  output logic                       rsp_err,
  output logic [DATA_W-1:0]          rsp_rd_data,
  output logic                       cpuif_req,
  output logic                       cpuif_req_is_wr,
  output logic [ADDR_W-1:0]          cpuif_addr,
  output logic [DATA_W-1:0]          cpuif_wr_data,
  output logic [DATA_W-1:0]          cpuif_wr_biten,
  input  logic                       cpuif_req_stall_wr,
  input  logic                       cpuif_req_stall_rd,
  input  logic                       cpuif_rd_ack,
  input  logic                       cpuif_rd_err,
  input  logic [DATA_W-1:0]          cpuif_rd_data,
  input  logic                       cpuif_wr_ack,
  input  logic                       cpuif_wr_err,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       timeout_evt
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("cpuif_rr_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_found;
  logic             do_grant, do_done, do_timeout;
  logic             stall, match_ack, match_err;

  // The latched payload registers double as the cpuif outputs.
  assign stall     = cpuif_req_is_wr ? cpuif_req_stall_wr : cpuif_req_stall_rd;
  assign match_ack = cpuif_req_is_wr ? cpuif_wr_ack : cpuif_rd_ack;
  assign match_err = cpuif_req_is_wr ? cpuif_wr_err : cpuif_rd_err;

  // Search from ptr+1 upward, wrapping; first set bit wins.
  always_comb begin : arb
    int unsigned cand;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!arb_found && req_vld[cand[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[IDX_W-1:0];
      end
    end
  end

`ifdef CPUIF_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tmo_cnt     <= '0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= do_timeout;
      if (do_grant)
        tmo_cnt <= '0;
      else if (state != IDLE)
        tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  assign timeout_evt = 1'b0;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_grant   = 1'b0;
    do_done    = 1'b0;
    do_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (arb_found) begin
          do_grant  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // An ack while stalled is not a completion; only the accepting edge counts.
        if (!stall) begin
          if (match_ack) begin
            do_done   = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (match_ack) begin
          do_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef CPUIF_ARB_TIMEOUT_EN
    // A real completion on the timeout edge takes precedence.
    if (state != IDLE && !do_done && tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      do_timeout = 1'b1;
      state_nxt  = IDLE;
    end
`endif
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ptr             <= IDX_W'(N_REQ - 1);
      grant_id        <= '0;
      req_accept      <= '0;
      rsp_ack         <= '0;
      rsp_err         <= 1'b0;
      rsp_rd_data     <= '0;
      cpuif_req       <= 1'b0;
      cpuif_req_is_wr <= 1'b0;
      cpuif_addr      <= '0;
      cpuif_wr_data   <= '0;
      cpuif_wr_biten  <= '0;
      busy            <= 1'b0;
    end else begin
      req_accept  <= '0;
      rsp_ack     <= '0;
      rsp_err     <= 1'b0;
      rsp_rd_data <= '0;
      cpuif_req   <= (state_nxt == ISSUE);
      busy        <= (state_nxt != IDLE);
      if (do_grant) begin
        req_accept[arb_idx] <= 1'b1;
        ptr                 <= arb_idx;
        grant_id            <= arb_idx;
        cpuif_req_is_wr     <= req_is_wr[arb_idx];
        cpuif_addr          <= req_addr[32'(arb_idx) * ADDR_W +: ADDR_W];
        cpuif_wr_data       <= req_wr_data[32'(arb_idx) * DATA_W +: DATA_W];
        cpuif_wr_biten      <= req_wr_biten[32'(arb_idx) * DATA_W +: DATA_W];
      end
      if (do_done) begin
        rsp_ack[ptr] <= 1'b1;
        rsp_err      <= match_err;
        rsp_rd_data  <= cpuif_req_is_wr ? '0 : cpuif_rd_data;
      end
      if (do_timeout) begin
        rsp_ack[ptr] <= 1'b1;
        rsp_err      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpuif_rr_arbiter.sv
// Scoreboard bench for cpuif_rr_arbiter: directed transactions, expected grants
// and responses queued by the stimulus, popped by a monitor on req_accept/rsp_ack.
module tb_cpuif_rr_arbiter;

  logic         clk = 1'b0;
  logic         arst_n;
  logic [3:0]   req_vld, req_is_wr;
  logic [127:0] req_addr, req_wr_data, req_wr_biten;
  logic [3:0]   req_accept, rsp_ack;
  logic         rsp_err;
  logic [31:0]  rsp_rd_data;
  logic         cpuif_req, cpuif_req_is_wr;
  logic [31:0]  cpuif_addr, cpuif_wr_data, cpuif_wr_biten;
  logic         cpuif_req_stall_wr, cpuif_req_stall_rd;
  logic         cpuif_rd_ack, cpuif_rd_err, cpuif_wr_ack, cpuif_wr_err;
  logic [31:0]  cpuif_rd_data;
  logic [1:0]   grant_id;
  logic         busy, timeout_evt;

  // regblock model outputs plus injected acks
  logic m_stall_wr, m_stall_rd, m_rd_ack, m_wr_ack, m_rd_err, m_wr_err;
  logic [31:0] m_rd_data;
  logic inj_rd_ack = 1'b0, inj_wr_ack = 1'b0;
  assign cpuif_req_stall_wr = m_stall_wr;
  assign cpuif_req_stall_rd = m_stall_rd;
  assign cpuif_rd_ack       = m_rd_ack | inj_rd_ack;
  assign cpuif_wr_ack       = m_wr_ack | inj_wr_ack;
  assign cpuif_rd_err       = m_rd_err;
  assign cpuif_wr_err       = m_wr_err;
  assign cpuif_rd_data      = m_rd_data;

  cpuif_rr_arbiter #(
    .N_REQ(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .req_vld(req_vld), .req_is_wr(req_is_wr), .req_addr(req_addr),
    .req_wr_data(req_wr_data), .req_wr_biten(req_wr_biten),
    .req_accept(req_accept), .rsp_ack(rsp_ack), .rsp_err(rsp_err), .rsp_rd_data(rsp_rd_data),
    .cpuif_req(cpuif_req), .cpuif_req_is_wr(cpuif_req_is_wr), .cpuif_addr(cpuif_addr),
    .cpuif_wr_data(cpuif_wr_data), .cpuif_wr_biten(cpuif_wr_biten),
    .cpuif_req_stall_wr(cpuif_req_stall_wr), .cpuif_req_stall_rd(cpuif_req_stall_rd),
    .cpuif_rd_ack(cpuif_rd_ack), .cpuif_rd_err(cpuif_rd_err), .cpuif_rd_data(cpuif_rd_data),
    .cpuif_wr_ack(cpuif_wr_ack), .cpuif_wr_err(cpuif_wr_err),
    .grant_id(grant_id), .busy(busy), .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  // ---------------- regblock model ----------------
  int          rb_stall_n = 0;   // stall cycles at start of each request
  int          rb_delay   = 0;   // 0: ack on accepting cycle, else cycles later
  bit          rb_noack   = 1'b0;
  bit          rb_err     = 1'b0;
  bit          rb_cross   = 1'b0; // hold the non-relevant stall high
  logic [31:0] rb_data    = '0;
  int          rb_req_cyc = 0, rb_wait_cyc = 0;
  bit          rb_pending = 1'b0;

  task automatic rb_ack();
    if (cpuif_req_is_wr) begin m_wr_ack = 1'b1; m_wr_err = rb_err; end
    else                 begin m_rd_ack = 1'b1; m_rd_err = rb_err; end
  endtask

  always @(negedge clk) begin
    m_stall_wr = 1'b0; m_stall_rd = 1'b0;
    m_rd_ack = 1'b0; m_wr_ack = 1'b0; m_rd_err = 1'b0; m_wr_err = 1'b0;
    m_rd_data = rb_data;
    if (!arst_n) begin
      rb_req_cyc = 0; rb_wait_cyc = 0; rb_pending = 1'b0;
    end else if (cpuif_req) begin
      if (cpuif_req_is_wr) m_stall_rd = rb_cross; else m_stall_wr = rb_cross;
      if (rb_req_cyc < rb_stall_n) begin
        if (cpuif_req_is_wr) m_stall_wr = 1'b1; else m_stall_rd = 1'b1;
      end else if (!rb_noack) begin
        if (rb_delay == 0) rb_ack();
        else begin rb_pending = 1'b1; rb_wait_cyc = 0; end
      end
      rb_req_cyc++;
    end else begin
      rb_req_cyc = 0;
      if (rb_pending) begin
        rb_wait_cyc++;
        if (rb_wait_cyc >= rb_delay) begin rb_ack(); rb_pending = 1'b0; end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { bit is_wr; logic [31:0] addr, data, biten; } txn_t;
  typedef struct { int gid; bit err; logic [31:0] rd; bit tmo; } rsp_t;
  txn_t txq[4][$];
  rsp_t exp_q[$];
  int   exp_gnt_q[$];

  int checks = 0, errors = 0;
  int inflight = 0, req_hi_cnt = 0, last_req_hi = 0;
  bit prev_req = 1'b0, tmo_seen = 1'b0;
  logic [31:0] prev_addr, prev_data, prev_biten, cap_addr, cap_data, cap_biten;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    rsp_t e;
    int   g;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        inflight = 0; req_hi_cnt = 0; prev_req = 1'b0;
      end else begin
        if (req_accept != 4'b0) begin
          if (exp_gnt_q.size() == 0) check("unexpected_accept", 64'(req_accept), 64'd0);
          else begin
            g = exp_gnt_q.pop_front();
            check("accept_vec", 64'(req_accept), 64'(4'b1 << g));
            check("grant_id", 64'(grant_id), 64'(g));
          end
          check("one_outstanding", 64'(inflight), 64'd0);
          inflight++;
        end
        if (rsp_ack != 4'b0) begin
          if (exp_q.size() == 0) check("unexpected_rsp", 64'(rsp_ack), 64'd0);
          else begin
            e = exp_q.pop_front();
            check("rsp_ack_vec", 64'(rsp_ack), 64'(4'b1 << e.gid));
            check("rsp_err", 64'(rsp_err), 64'(e.err));
            check("rsp_rd_data", 64'(rsp_rd_data), 64'(e.rd));
            check("rsp_timeout_evt", 64'(timeout_evt), 64'(e.tmo));
          end
          if (inflight > 0) inflight--;
          last_req_hi = req_hi_cnt;
          req_hi_cnt  = 0;
        end
        if (cpuif_req) begin
          if (prev_req) begin
            check("payload_addr_stable", 64'(cpuif_addr), 64'(prev_addr));
            check("payload_data_stable", 64'(cpuif_wr_data), 64'(prev_data));
            check("payload_biten_stable", 64'(cpuif_wr_biten), 64'(prev_biten));
          end else begin
            cap_addr = cpuif_addr; cap_data = cpuif_wr_data; cap_biten = cpuif_wr_biten;
          end
          req_hi_cnt++;
        end
        prev_req = cpuif_req;
        prev_addr = cpuif_addr; prev_data = cpuif_wr_data; prev_biten = cpuif_wr_biten;
        if (timeout_evt) tmo_seen = 1'b1;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic add_txn(input int g, input bit wr, input logic [31:0] a, d, b);
    txn_t t;
    t.is_wr = wr; t.addr = a; t.data = d; t.biten = b;
    txq[g].push_back(t);
  endtask

  task automatic expect_rsp(input int g, input bit err, input logic [31:0] rd, input bit tmo);
    rsp_t e;
    e.gid = g; e.err = err; e.rd = rd; e.tmo = tmo;
    exp_q.push_back(e);
  endtask

  task automatic present(input int g);
    if (txq[g].size() > 0) begin
      req_vld[g]               = 1'b1;
      req_is_wr[g]             = txq[g][0].is_wr;
      req_addr[g*32 +: 32]     = txq[g][0].addr;
      req_wr_data[g*32 +: 32]  = txq[g][0].data;
      req_wr_biten[g*32 +: 32] = txq[g][0].biten;
    end else begin
      req_vld[g] = 1'b0;
    end
  endtask

  function automatic bit txn_left();
    bit r = 1'b0;
    for (int g = 0; g < 4; g++) if (txq[g].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic drive(input int max_cycles);
    int n = 0;
    for (int g = 0; g < 4; g++) present(g);
    while ((txn_left() || busy || exp_q.size() > 0) && n < max_cycles) begin
      @(posedge clk); #1;
      for (int g = 0; g < 4; g++)
        if (req_accept[g]) begin void'(txq[g].pop_front()); present(g); end
      n++;
    end
    if (n >= max_cycles) check("drive_cycle_budget", 64'(n), 64'(max_cycles - 1));
  endtask

  task automatic wait_accept(input int g, input int max_cycles);
    int n = 0;
    present(g);
    do begin @(posedge clk); #1; n++; end while (!req_accept[g] && n < max_cycles);
    check("accept_seen", 64'(req_accept[g]), 64'd1);
    void'(txq[g].pop_front());
    present(g);
  endtask

  // ---------------- tests ----------------
  int t2_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int cnt;

  initial begin
    arst_n = 1'b0;
    req_vld = '0; req_is_wr = '0; req_addr = '0; req_wr_data = '0; req_wr_biten = '0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    check("rst_req_accept", 64'(req_accept), 64'd0);
    check("rst_rsp_ack", 64'(rsp_ack), 64'd0);
    check("rst_rsp_err_data", 64'({rsp_err, rsp_rd_data}), 64'd0);
    check("rst_cpuif_ctl", 64'({cpuif_req, cpuif_req_is_wr, grant_id, busy, timeout_evt}), 64'd0);
    check("rst_cpuif_addr", 64'(cpuif_addr), 64'd0);
    check("rst_cpuif_wdata_biten", {cpuif_wr_data, cpuif_wr_biten}, 64'd0);
    @(posedge clk); #1 arst_n = 1'b1;

    // T1: single read, same-cycle ack
    rb_data = 32'hA5A5_0001;
    add_txn(0, 1'b0, 32'h10, 32'h0, 32'h0);
    exp_gnt_q.push_back(0);
    expect_rsp(0, 1'b0, 32'hA5A5_0001, 1'b0);
    @(posedge clk); #1 present(0);
    @(negedge clk);
    check("t1_no_accept_yet", 64'(req_accept), 64'd0);
    @(negedge clk);
    check("t1_accept", 64'(req_accept), 64'h1);
    check("t1_cpuif_req", 64'(cpuif_req), 64'd1);
    check("t1_cpuif_addr", 64'(cpuif_addr), 64'h10);
    check("t1_is_wr", 64'(cpuif_req_is_wr), 64'd0);
    void'(txq[0].pop_front()); present(0);
    @(negedge clk);
    check("t1_rsp_latency", 64'(rsp_ack), 64'h1);
    check("t1_cpuif_req_low", 64'(cpuif_req), 64'd0);
    @(negedge clk);
    check("t1_idle", 64'(busy), 64'd0);

    // T3: write stalled 5 cycles on req3 (stall_rd held high, must be ignored)
    rb_stall_n = 5; rb_cross = 1'b1; rb_data = 32'hFFFF_FFFF;
    add_txn(3, 1'b1, 32'h24, 32'hDEAD_BEEF, 32'h0000_FFFF);
    exp_gnt_q.push_back(3);
    expect_rsp(3, 1'b0, 32'h0, 1'b0);
    drive(60);
    check("t3_req_cycles", 64'(last_req_hi), 64'd6);
    check("t3_addr", 64'(cap_addr), 64'h24);
    check("t3_wdata", 64'(cap_data), 64'hDEAD_BEEF);
    check("t3_biten", 64'(cap_biten), 64'h0000_FFFF);

    // T2: all four requesters, two writes each, ack one cycle after accept
    rb_stall_n = 0; rb_delay = 1;
    for (int k = 0; k < 2; k++)
      for (int g = 0; g < 4; g++)
        add_txn(g, 1'b1, 32'h100 + 32'(g * 16 + k * 4), 32'h1111_0000 + 32'(g * 2 + k), 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) begin
      exp_gnt_q.push_back(t2_order[i]);
      expect_rsp(t2_order[i], 1'b0, 32'h0, 1'b0);
    end
    drive(200);

    // T4: read error on req2; a non-matching wr_ack in WAIT is ignored
    rb_delay = 3; rb_err = 1'b1; rb_data = 32'h1234_5678;
    add_txn(2, 1'b0, 32'h48, 32'h0, 32'h0);
    exp_gnt_q.push_back(2);
    expect_rsp(2, 1'b1, 32'h1234_5678, 1'b0);
    wait_accept(2, 10);
    @(negedge clk);
    @(negedge clk); inj_wr_ack = 1'b1;
    @(negedge clk); inj_wr_ack = 1'b0;
    check("t4_still_busy", 64'(busy), 64'd1);
    check("t4_no_early_rsp", 64'(rsp_ack), 64'd0);
    drive(20);
    rb_err = 1'b0; rb_delay = 0; rb_cross = 1'b0;

    // T5: reset during WAIT of req1
    rb_noack = 1'b1; rb_data = 32'h0BAD_F00D;
    add_txn(1, 1'b0, 32'h80, 32'h0, 32'h0);
    exp_gnt_q.push_back(1);
    wait_accept(1, 10);
    @(negedge clk);
    @(negedge clk);
    check("t5_in_wait", 64'({busy, cpuif_req}), 64'b10);
    #2 arst_n = 1'b0;
    #1;
    check("t5_rst_ctl", 64'({req_accept, rsp_ack, rsp_err, cpuif_req, busy, grant_id, timeout_evt}), 64'd0);
    check("t5_rst_addr", 64'(cpuif_addr), 64'd0);
    @(negedge clk);
    @(posedge clk); #1 arst_n = 1'b1;
    rb_noack = 1'b0;
    @(negedge clk); inj_rd_ack = 1'b1;
    @(negedge clk); inj_rd_ack = 1'b0;
    check("t5_stale_ack_rsp", 64'(rsp_ack), 64'd0);
    @(negedge clk);
    check("t5_stale_ack_rsp2", 64'({rsp_ack, busy}), 64'd0);
    add_txn(1, 1'b0, 32'h84, 32'h0, 32'h0);
    add_txn(3, 1'b0, 32'h8C, 32'h0, 32'h0);
    add_txn(0, 1'b0, 32'h88, 32'h0, 32'h0);
    exp_gnt_q.push_back(0); exp_gnt_q.push_back(1); exp_gnt_q.push_back(3);
    expect_rsp(0, 1'b0, 32'h0BAD_F00D, 1'b0);
    expect_rsp(1, 1'b0, 32'h0BAD_F00D, 1'b0);
    expect_rsp(3, 1'b0, 32'h0BAD_F00D, 1'b0);
    drive(60);

`ifdef CPUIF_ARB_TIMEOUT_EN
    // T6: no ack -> forced error completion 16 cycles after issue
    rb_noack = 1'b1; rb_data = 32'h7777_7777;
    add_txn(2, 1'b1, 32'hC0, 32'h5555_AAAA, 32'hFFFF_FFFF);
    exp_gnt_q.push_back(2);
    expect_rsp(2, 1'b1, 32'h0, 1'b1);
    wait_accept(2, 10);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_ack != 4'b0) break;
      cnt++;
    end
    check("t6_timeout_latency", 64'(cnt), 64'd16);
    check("t6_timeout_evt", 64'(timeout_evt), 64'd1);
    @(negedge clk); inj_wr_ack = 1'b1;
    @(negedge clk); inj_wr_ack = 1'b0;
    check("t6_late_ack_ignored", 64'({rsp_ack, busy, timeout_evt}), 64'd0);
    rb_noack = 1'b0;
`else
    check("no_timeout_evt", 64'(tmo_seen), 64'd0);
`endif

    repeat (3) @(negedge clk);
    check("exp_rsp_drained", 64'(exp_q.size()), 64'd0);
    check("exp_gnt_drained", 64'(exp_gnt_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
